uart_tx_mmio: RTL
=================

Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter that sits downstream of the single-cycle core's data-memory port, alongside datamem. It snoops the store bus (writeEn/addr/func3/storeVal), captures stores to a TX address into a small FIFO, and serialises each byte as 8N1 on txd. A status word is returned on loads to a STAT address so firmware can poll it, giving the core printable output beyond the 10-bit out port.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; must be >= 2
FIFO_DEPTH, 8, byte entries; power of 2, 2..16
TX_ADDR, 32'h0000_0400, byte address of the transmit data register
STAT_ADDR, 32'h0000_0404, byte address of the status/control register

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high
writeEn  in  1  store strobe from core, same as datamem writeEn
addr  in  32  data address from ALU result
func3  in  3  load/store width code; ignored for TX/STAT hits
storeVal  in  32  rs2 store data
loadVal  out  32  status word; valid when sel=1, else 0
sel  out  1  combinational, addr==TX_ADDR or addr==STAT_ADDR; top muxes loadVal over datamem
txd  out  1  serial output, idle high
busy  out  1  high when FSM not IDLE or FIFO non-empty

Behaviour:
- Reset (sampled on posedge clk): txd=1, busy=0, FIFO empty (count=0, pointers 0), overflow=0, state IDLE, shift reg and bit/clock counters 0. Reset mid-frame aborts the frame: txd=1 from the next edge; no partial byte is resumed.
- Push: writeEn && addr==TX_ADDR at posedge pushes storeVal[7:0]. sb/sh/sw are all accepted; low byte only.
- Full: fullness is evaluated before a same-cycle pop, so a push while count==FIFO_DEPTH is dropped even if a pop occurs that edge. A dropped push sets sticky overflow.
- Control: writeEn && addr==STAT_ADDR with storeVal[0]=1 clears overflow. Other bits are ignored. A same-edge overflow set takes priority over the clear.
- Status loadVal, combinational:
  - bit0 empty
  - bit1 full
  - bit2 tx_active (state != IDLE)
  - bit3 overflow
  - bits[8+:5] count
  - all other bits 0
  - The value is the same for either address hit. loadVal=0 when sel=0.
- FSM states: IDLE, START, DATA, STOP. A clock-divider counter runs 0..CLKS_PER_BIT-1 and a bit index runs 0..7.
  - IDLE: txd=1. If FIFO non-empty, pop head into the shift reg, go to START, clear the divider.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right. After bit 7, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles. At the end, if FIFO non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Latency: push at edge N makes the FIFO non-empty after N. IDLE pops at edge N+1, and txd falls after edge N+1. A push and an IDLE pop on the same edge: the pop sees only prior contents.
- Timing: one frame = 10*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- Simultaneous push and pop when not full: count unchanged, both take effect.
- Wrap-around: pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is separate, log2+1 bits.

Decomposition:
- Package uart_pkg: FSM state encoding (2-bit localparams), status bit indices (ST_EMPTY=0, ST_FULL=1, ST_ACTIVE=2, ST_OVF=3, ST_CNT_LSB=8), default TX_ADDR/STAT_ADDR constants.
- Sub-module sync_fifo (params WIDTH=8, DEPTH):
  - inputs: clk, reset, push, pop, din
  - outputs: dout, full, empty, count
  - first-word-fall-through; drop on push-when-full
  - reusable elsewhere in the core.
- The top holds the address decode, overflow flag, and TX FSM.

Test Plan:
- Reset held 3 cycles, then released -> txd=1, busy=0, sel=0 at addr 0; load at STAT_ADDR gives loadVal=32'h0000_0001.
- CLKS_PER_BIT=4: sb 0xA5 to TX_ADDR at edge N -> txd low from N+1 for 4 cycles; data 1,0,1,0,0,1,0,1 at 4 cycles each; stop high 4 cycles; busy falls at N+41; status returns to 0x1.
- 10 sw on consecutive edges to TX_ADDR (bytes 0x30..0x39) with DEPTH=8 -> status full (0x802 | active bit) after the 9th write; 10th (0x39) dropped, overflow bit3=1; exactly 9 contiguous frames 0x30..0x38 (360 cycles), no idle gaps.
- After the test above, store 32'h1 to STAT_ADDR -> bit3 reads 0 next cycle; store 32'h0 -> no effect.
- sw 32'h1234_5678 to TX_ADDR -> frame carries 0x78; sh 16'hBEEF -> frame carries 0xEF; a store to TX_ADDR+8 -> no push, sel=0.
- Reset asserted during DATA bit 3 of a frame with 2 bytes queued -> txd=1 next edge, status 0x1, no further frames; overflow cleared.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared encodings for the memory-mapped UART transmitter: FSM states,
// status-word bit positions and default register addresses.
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_ACTIVE  = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 8;

    localparam logic [31:0] DEF_TX_ADDR   = 32'h0000_0400;
    localparam logic [31:0] DEF_STAT_ADDR = 32'h0000_0404;

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// First-word-fall-through synchronous FIFO; pushes while full are dropped.
// Fullness is judged on the pre-edge count, so a same-edge pop does not make room.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Store-bus snooping UART transmitter: TX_ADDR stores queue a byte, STAT_ADDR
// loads return FIFO/FSM status, and queued bytes go out back-to-back as 8N1.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] TX_ADDR      = DEF_TX_ADDR,
    parameter logic [31:0] STAT_ADDR    = DEF_STAT_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        writeEn,
    input  logic [31:0] addr,
    input  logic [2:0]  func3,
    input  logic [31:0] storeVal,
    output logic [31:0] loadVal,
    output logic        sel,
    output logic        txd,
    output logic        busy
);

    localparam int             CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int             DW       = $clog2(CLKS_PER_BIT);
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          ovf_q, ovf_d;

    logic          hit_tx, hit_stat, push_req, ovf_clr, bit_end;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status;
    logic          unused_bits;

    // Width code and upper store bits carry no meaning for these registers.
    assign unused_bits = ^{func3, storeVal[31:8]};

    assign hit_tx   = (addr == TX_ADDR);
    assign hit_stat = (addr == STAT_ADDR);
    assign sel      = hit_tx || hit_stat;
    assign push_req = writeEn && hit_tx;
    assign ovf_clr  = writeEn && hit_stat && storeVal[0];
    assign busy     = (state_q != S_IDLE) || !fifo_empty;
    assign bit_end  = (div_q == DIV_LAST);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (fifo_pop),
        .din   (storeVal[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A dropped push wins over a same-edge clear.
    assign ovf_d = (push_req && fifo_full) ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

    always_comb begin
        status                     = '0;
        status[ST_EMPTY]           = fifo_empty;
        status[ST_FULL]            = fifo_full;
        status[ST_ACTIVE]          = (state_q != S_IDLE);
        status[ST_OVF]             = ovf_q;
        status[ST_CNT_LSB +: 5]    = 5'(fifo_count);
        loadVal                    = sel ? status : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        txd      = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    div_d    = '0;
                    state_d  = S_START;
                end
            end
            S_START: begin
                txd = 1'b0;
                if (bit_end) begin
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_DATA: begin
                txd = shift_q[0];
                if (bit_end) begin
                    div_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    div_d = '0;
                    // Chain straight into the next start bit when more data is queued.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        state_d  = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
